// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin arbiter sharing one memory port between the
// instruction-fetch requester (I) and the load/store requester (D).
// Each granted request is latched onto the memory port until mem_valid,
// or until the watchdog gives up, and a one-cycle completion pulse is
// returned to the owning requester.
module imem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_valid,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              d_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic              busy
);

   // A zero TIMEOUT still gets a 1-bit counter so no zero-width vectors appear.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   // Expiry is flagged one count early so the pulse lands T cycles after
   // the first busy cycle (the count starts at 0 in that cycle).
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit WDOG_EN = (TIMEOUT != 0);

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

   state_t            state, state_next;
   logic              last_grant, last_grant_next;
   logic [CNT_W-1:0]  count, count_next;

   logic              mem_req_next, mem_we_next;
   logic [ADDR_W-1:0] mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_next;
   logic              i_valid_next, i_err_next, d_valid_next, d_err_next;
   logic [DATA_W-1:0] i_rdata_next, d_rdata_next;

   logic              i_elig, d_elig, grant_i, grant_d, expired;

   // A requester whose completion pulse is showing this cycle is still holding
   // req for the finished transaction, so it must not be granted again yet.
   assign i_elig  = i_req & ~i_valid;
   assign d_elig  = d_req & ~d_valid;
   assign grant_i = i_elig & (~d_elig | (last_grant == GRANT_D));
   assign grant_d = d_elig & ~grant_i;
   assign expired = WDOG_EN && !mem_valid && (count == CNT_LAST);
   assign busy    = (state != IDLE);

   // State, fairness pointer and watchdog counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= GRANT_D;
         count      <= '0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         count      <= count_next;
      end
   end

   // Registered memory-port and requester-side outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_valid   <= 1'b0;
         i_err     <= 1'b0;
         i_rdata   <= '0;
         d_valid   <= 1'b0;
         d_err     <= 1'b0;
         d_rdata   <= '0;
      end else begin
         mem_req   <= mem_req_next;
         mem_we    <= mem_we_next;
         mem_addr  <= mem_addr_next;
         mem_wdata <= mem_wdata_next;
         i_valid   <= i_valid_next;
         i_err     <= i_err_next;
         i_rdata   <= i_rdata_next;
         d_valid   <= d_valid_next;
         d_err     <= d_err_next;
         d_rdata   <= d_rdata_next;
      end
   end

   // Next-state: grant in IDLE, then wait for completion or watchdog expiry.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      count_next      = count;
      mem_req_next    = mem_req;
      mem_we_next     = mem_we;
      mem_addr_next   = mem_addr;
      mem_wdata_next  = mem_wdata;
      i_valid_next    = 1'b0;
      i_err_next      = 1'b0;
      i_rdata_next    = i_rdata;
      d_valid_next    = 1'b0;
      d_err_next      = 1'b0;
      d_rdata_next    = d_rdata;

      case (state)
         IDLE: begin
            if (grant_i) begin
               state_next      = I_BUSY;
               last_grant_next = GRANT_I;
               count_next      = '0;
               mem_req_next    = 1'b1;
               mem_we_next     = 1'b0;
               mem_addr_next   = i_addr;
            end else if (grant_d) begin
               state_next      = D_BUSY;
               last_grant_next = GRANT_D;
               count_next      = '0;
               mem_req_next    = 1'b1;
               mem_we_next     = d_we;
               mem_addr_next   = d_addr;
               mem_wdata_next  = d_wdata;
            end
         end

         I_BUSY: begin
            if (mem_valid) begin
               state_next   = IDLE;
               mem_req_next = 1'b0;
               i_valid_next = 1'b1;
               i_rdata_next = mem_rdata;
            end else if (expired) begin
               state_next   = IDLE;
               mem_req_next = 1'b0;
               i_valid_next = 1'b1;
               i_err_next   = 1'b1;
               i_rdata_next = '0;
            end else if (count != CNT_MAX) begin
               count_next = count + 1'b1;
            end
         end

         D_BUSY: begin
            if (mem_valid) begin
               state_next   = IDLE;
               mem_req_next = 1'b0;
               d_valid_next = 1'b1;
               // Writes leave the last read result visible.
               if (!mem_we) begin
                  d_rdata_next = mem_rdata;
               end
            end else if (expired) begin
               state_next   = IDLE;
               mem_req_next = 1'b0;
               d_valid_next = 1'b1;
               d_err_next   = 1'b1;
               d_rdata_next = '0;
            end else if (count != CNT_MAX) begin
               count_next = count + 1'b1;
            end
         end

         default: begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter that shares a single instruction/data memory port between the instruction-fetch path (ICache miss side) and the data path (load/store unit). It serialises requests with round-robin fairness and latches each granted request onto the memory port until the memory signals completion. It returns read data and a one-cycle completion pulse to the owning requester. A watchdog aborts transactions that the memory never completes.

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles to wait for mem_valid per transaction; 0 disables the watchdog

- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  instruction read request; held high until i_valid
- i_addr  in  ADDR_W  instruction address; stable while i_req high
- i_rdata  out  DATA_W  instruction read data, valid with i_valid
- i_valid  out  1  one-cycle completion pulse for instruction side
- i_err  out  1  qualifies i_valid: transaction timed out
- d_req  in  1  data request; held high until d_valid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  data read result, valid with d_valid on reads
- d_valid  out  1  one-cycle completion pulse for data side
- d_err  out  1  qualifies d_valid: transaction timed out
- mem_req  out  1  memory transaction active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_valid
- mem_valid  in  1  memory completion, sampled only while mem_req high
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY. Register last_grant (I or D).
- IDLE grant eligibility: a requester is eligible iff its req is high and its own valid output is low in that cycle. This prevents re-granting a request that is being completed.
- Only one requester eligible: grant it.
- Both requesters eligible: grant the one that is not last_grant. last_grant resets to D, so the first tie goes to I.
- On grant: capture address (plus d_we and d_wdata for D; mem_we = 0 for I) into the mem_* registers, set mem_req = 1, update last_grant, and enter I_BUSY or D_BUSY.
- BUSY states:
  - mem_* outputs are held constant.
  - The watchdog counter clears on grant and increments each cycle that mem_valid is low.
- Completion in BUSY (mem_valid = 1):
  - mem_req drops to 0 and the FSM returns to IDLE.
  - The owner's valid pulses for one cycle with err = 0.
  - On reads, the owner's rdata is loaded with mem_rdata. On D writes, d_rdata holds its previous value.
- Timeout (TIMEOUT ≠ 0): when the counter reaches TIMEOUT with mem_valid low:
  - mem_req drops to 0 and the FSM returns to IDLE.
  - The owner's valid pulses with err = 1 and its rdata is set to 0.
- If mem_valid and the timeout condition occur in the same cycle, mem_valid wins (normal completion).
- mem_valid seen in IDLE is ignored; no outputs change.
- err outputs are meaningful only while valid is high and are 0 otherwise.
- Counter width is ceil(log2(TIMEOUT+1)); the counter saturates and never wraps.

## Timing
- Reset values:
  - All outputs 0: i_rdata, d_rdata, i_valid, d_valid, i_err, d_err, mem_req, mem_we, mem_addr, mem_wdata, busy.
  - State = IDLE, last_grant = D, counter = 0.
- Reset mid-transaction: immediate return to reset values; the in-flight transaction is dropped with no valid pulse.
- Request in IDLE at cycle N: mem_req, mem_addr and busy are high from N+1.
- mem_valid at cycle M (in BUSY): valid/rdata/err are registered and visible at M+1; mem_req is low at M+1; state is IDLE at M+1.
- Minimum back-to-back spacing:
  - The next grant is decided at M+1, with mem_req high again at M+2.
  - Single-cycle memory: a transaction every 3 cycles per port; with both requesters active, grants alternate I, D, I, D.
- Timeout: with TIMEOUT = T granted at N, mem_valid never arriving → err/valid pulse at N+1+T.

## Test plan
- Single I read:
  - Stimulus: i_req with i_addr = 0x100; memory returns 0xDEADBEEF 1 cycle after mem_req.
  - Required: mem_addr = 0x100 and mem_we = 0; i_valid one cycle with i_rdata = 0xDEADBEEF and i_err = 0; d_valid stays 0.
- D write then D read:
  - Stimulus: write 0xCAFEF00D to 0x200, then read 0x200 from a model memory.
  - Required: mem_we = 1 with mem_wdata = 0xCAFEF00D; d_valid pulses; the read returns d_rdata = 0xCAFEF00D.
- Fairness:
  - Stimulus: i_req and d_req held continuously from reset, with each requester re-requesting right after its valid.
  - Required: grant order I, D, I, D…; no requester is granted twice in a row while the other is waiting.
- Timeout:
  - Stimulus: TIMEOUT = 4, mem_valid tied low, d_req read.
  - Required: d_valid = 1, d_err = 1 and d_rdata = 0 exactly 5 cycles after the grant cycle; mem_req = 0 afterwards.
  - Repeat with mem_valid on the same cycle as expiry → required d_err = 0.
- Reset mid-op:
  - Stimulus: assert reset while in I_BUSY.
  - Required: mem_req, busy and all valid/err outputs at 0 asynchronously; no i_valid after release; the next tie after reset is granted to I.
- Spurious mem_valid:
  - Stimulus: pulse mem_valid while in IDLE.
  - Required: no valid pulse; rdata outputs unchanged.
